// File: rtl/imem_loader_if.sv
// Byte-stream, instruction-memory write port and status bundle for imem_loader.
// The master side is the host/boot logic; the slave side is the loader itself.
interface imem_loader_if;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        restart;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        cpu_hold;
  logic        done;
  logic        error;

  modport master (
    output in_valid, in_data, restart,
    input  in_ready, mem_we, mem_addr, mem_wdata, cpu_hold, done, error
  );

  modport slave (
    input  in_valid, in_data, restart,
    output in_ready, mem_we, mem_addr, mem_wdata, cpu_hold, done, error
  );
endinterface

// File: rtl/imem_loader.sv
// Boot-time instruction memory loader: length header + little-endian words -> write port.
// Define IMEM_LOADER_CHECKSUM_EN to require a trailing mod-256 payload checksum byte.
module imem_loader #(
  parameter int unsigned DEPTH = 256
) (
  input  logic         clk,
  input  logic         rst,
  imem_loader_if.slave bus
);

`ifdef IMEM_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {HDR, DATA, CSUM, FIN, DONE, ERR} state_t;
  localparam state_t PAYLOAD_END = CSUM;
`else
  typedef enum logic [2:0] {HDR, DATA, FIN, DONE, ERR} state_t;
  localparam state_t PAYLOAD_END = FIN;
`endif

  state_t      state_q, state_d;
  logic [1:0]  byte_idx_q, byte_idx_d;
  logic [31:0] word_cnt_q, word_cnt_d;
  logic [31:0] count_q, count_d;
  logic [23:0] acc_q, acc_d;
  logic        mem_we_q, mem_we_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic        ready;
  logic        accept;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]  sum_q, sum_d;
`endif

`ifdef IMEM_LOADER_CHECKSUM_EN
  assign ready = (state_q == HDR) || (state_q == DATA) || (state_q == CSUM);
`else
  assign ready = (state_q == HDR) || (state_q == DATA);
`endif
  assign accept = bus.in_valid && ready;

  always_comb begin
    state_d     = state_q;
    byte_idx_d  = byte_idx_q;
    word_cnt_d  = word_cnt_q;
    count_d     = count_q;
    acc_d       = acc_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
    sum_d       = sum_q;
`endif
    case (state_q)
      HDR: begin
        if (accept) begin
          byte_idx_d = byte_idx_q + 2'd1;
          count_d    = {bus.in_data, count_q[31:8]};
          if (byte_idx_q == 2'd3) begin
            if (count_d > 32'(DEPTH))
              state_d = ERR;
            else if (count_d == 32'd0)
              state_d = PAYLOAD_END;
            else
              state_d = DATA;
          end
        end
      end
      DATA: begin
        if (accept) begin
          byte_idx_d = byte_idx_q + 2'd1;
          acc_d      = {bus.in_data, acc_q[23:8]};
`ifdef IMEM_LOADER_CHECKSUM_EN
          sum_d      = sum_q + bus.in_data;
`endif
          // The accumulator already holds b2,b1,b0 in its top-to-bottom bytes.
          if (byte_idx_q == 2'd3) begin
            mem_we_d    = 1'b1;
            mem_addr_d  = word_cnt_q << 2;
            mem_wdata_d = {bus.in_data, acc_q};
            word_cnt_d  = word_cnt_q + 32'd1;
            if (word_cnt_d == count_q)
              state_d = PAYLOAD_END;
          end
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      CSUM: begin
        if (accept)
          state_d = (bus.in_data == sum_q) ? FIN : ERR;
      end
`endif
      FIN: state_d = DONE;
      DONE, ERR: begin
        if (bus.restart) begin
          state_d    = HDR;
          byte_idx_d = 2'd0;
          word_cnt_d = 32'd0;
          count_d    = 32'd0;
          acc_d      = 24'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
          sum_d      = 8'd0;
`endif
        end
      end
      default: state_d = HDR;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= HDR;
      byte_idx_q  <= 2'd0;
      word_cnt_q  <= 32'd0;
      count_q     <= 32'd0;
      acc_q       <= 24'd0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 32'd0;
      mem_wdata_q <= 32'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      sum_q       <= 8'd0;
`endif
    end else begin
      state_q     <= state_d;
      byte_idx_q  <= byte_idx_d;
      word_cnt_q  <= word_cnt_d;
      count_q     <= count_d;
      acc_q       <= acc_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
      sum_q       <= sum_d;
`endif
    end
  end

  assign bus.in_ready  = ready;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.cpu_hold  = (state_q != DONE);
  assign bus.done      = (state_q == DONE);
  assign bus.error     = (state_q == ERR);

endmodule
